// File: rtl/rvfi_imem_check.sv
// rvfi_imem_check: halfword-organised memory model serving a valid/ready bus,
// plus a retirement checker that compares every RVFI-retired instruction
// against the array contents at the retired PC.
//
// Optional build macro MEMCHECK_FORMAL_EN: when defined, mismatches fire a
// clocked immediate assert, bus stability is assumed while a transfer is
// pending, and the array power-up contents are left unconstrained. When
// undefined, mismatches appear only on the status ports and the array
// powers up as zero.
module rvfi_imem_check #(
  parameter int ADDR_BITS  = 11,
  parameter int NRET       = 1,
  parameter int COMPRESSED = 0,
  parameter int MAX_WAIT   = 7,
  parameter int WW         = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 mem_valid,
  input  logic                 mem_instr,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_wstrb,
  input  logic [WW-1:0]        wait_cycles,
  output logic                 mem_ready,
  output logic [31:0]          mem_rdata,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [32*NRET-1:0]   rvfi_insn,
  input  logic [32*NRET-1:0]   rvfi_pc_rdata,
  output logic                 chk_error,
  output logic [15:0]          chk_err_count,
  output logic [31:0]          chk_err_pc,
  output logic [31:0]          chk_err_insn,
  output logic [7:0]           chk_err_chan,
  output logic                 proto_err
);

  localparam int HW    = ADDR_BITS - 1;
  localparam int DEPTH = 1 << HW;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

`ifdef MEMCHECK_FORMAL_EN
  (* anyinit *) logic [15:0] mem [DEPTH];
`else
  logic [15:0] mem [DEPTH] = '{default: 16'h0000};
`endif

  state_t          state_p1, state_n;
  logic [WW-1:0]   wcnt_p1, wcnt_n;
  logic [31:0]     rdata_p1;
  logic            load_rdata, do_write, set_proto;
  logic [HW-1:0]   bus_h, bus_h1;
  logic [NRET-1:0] fail;
  logic [16:0]     nfail;
  logic [31:0]     first_pc, first_insn;
  logic [7:0]      first_chan;
  logic            unused_bits;

  // Wait-state requests beyond the supported maximum are clamped.
  function automatic logic [WW-1:0] clamp_wait(input logic [WW-1:0] w);
    if (w > WW'(MAX_WAIT)) return WW'(MAX_WAIT);
    return w;
  endfunction

  // Error count add that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [16:0] b);
    logic [17:0] s;
    s = {2'b00, a} + {1'b0, b};
    if (s > 18'h0FFFF) return 16'hFFFF;
    return s[15:0];
  endfunction

  assign unused_bits = &{1'b0, mem_instr, mem_addr, rvfi_pc_rdata};
  assign mem_rdata   = rdata_p1;

  // Bus halfword index; word-only builds ignore address bit 1.
  always_comb begin
    bus_h = mem_addr[ADDR_BITS-1:1];
    if (COMPRESSED == 0) bus_h[0] = 1'b0;
    bus_h1 = bus_h + HW'(1);
  end

  // Bus FSM next state, ready strobe and write/protocol qualifiers.
  always_comb begin
    state_n    = state_p1;
    wcnt_n     = wcnt_p1;
    load_rdata = 1'b0;
    do_write   = 1'b0;
    set_proto  = 1'b0;
    mem_ready  = 1'b0;
    case (state_p1)
      IDLE: begin
        if (mem_valid) begin
          wcnt_n = clamp_wait(wait_cycles);
          if (wcnt_n == '0) begin
            state_n    = RESP;
            load_rdata = 1'b1;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (!mem_valid) begin
          set_proto = 1'b1;
          state_n   = IDLE;
        end else if (wcnt_p1 == WW'(1)) begin
          wcnt_n     = '0;
          state_n    = RESP;
          load_rdata = 1'b1;
        end else begin
          wcnt_n = wcnt_p1 - WW'(1);
        end
      end
      RESP: begin
        state_n = IDLE;
        if (!mem_valid) begin
          set_proto = 1'b1;
        end else begin
          mem_ready = 1'b1;
          do_write  = |mem_wstrb;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Bus FSM state, wait counter, read data capture and protocol flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_p1  <= IDLE;
      wcnt_p1   <= '0;
      rdata_p1  <= '0;
      proto_err <= 1'b0;
    end else begin
      state_p1 <= state_n;
      wcnt_p1  <= wcnt_n;
      if (load_rdata) rdata_p1 <= {mem[bus_h1], mem[bus_h]};
      if (set_proto) proto_err <= 1'b1;
    end
  end

  // Byte-strobed array write in the completing cycle; contents never reset.
  always_ff @(posedge clk) begin
    if (resetn && do_write) begin
      if (mem_wstrb[0]) mem[bus_h][7:0]   <= mem_wdata[7:0];
      if (mem_wstrb[1]) mem[bus_h][15:8]  <= mem_wdata[15:8];
      if (mem_wstrb[2]) mem[bus_h1][7:0]  <= mem_wdata[23:16];
      if (mem_wstrb[3]) mem[bus_h1][15:8] <= mem_wdata[31:24];
    end
  end

  // Per-channel compare against the pre-write array snapshot.
  always_comb begin
    logic [HW-1:0] ch_h, ch_h1;
    logic [31:0]   ch_insn;
    logic          lo_bad, hi_bad, bad;
    fail    = '0;
    ch_h    = '0;
    ch_h1   = '0;
    ch_insn = '0;
    lo_bad  = 1'b0;
    hi_bad  = 1'b0;
    bad     = 1'b0;
    for (int c = 0; c < NRET; c++) begin
      ch_h    = rvfi_pc_rdata[32*c+1 +: HW];
      ch_h1   = ch_h + HW'(1);
      ch_insn = rvfi_insn[32*c +: 32];
      lo_bad  = ch_insn[15:0] != mem[ch_h];
      hi_bad  = ch_insn[31:16] != mem[ch_h1];
      if (ch_insn[1:0] == 2'b11) bad = lo_bad | hi_bad;
      else                       bad = lo_bad | (COMPRESSED == 0);
      fail[c] = rvfi_valid[c] & bad;
    end
  end

  // Failing-channel count and lowest-index failing channel for capture.
  always_comb begin
    nfail      = '0;
    first_pc   = '0;
    first_insn = '0;
    first_chan = '0;
    for (int c = 0; c < NRET; c++) nfail = nfail + 17'(fail[c]);
    for (int c = NRET - 1; c >= 0; c--) begin
      if (fail[c]) begin
        first_pc   = rvfi_pc_rdata[32*c +: 32];
        first_insn = rvfi_insn[32*c +: 32];
        first_chan = 8'(c);
      end
    end
  end

  // Sticky error flag, saturating count and first-mismatch capture.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      chk_error     <= 1'b0;
      chk_err_count <= '0;
      chk_err_pc    <= '0;
      chk_err_insn  <= '0;
      chk_err_chan  <= '0;
    end else if (|fail) begin
      chk_err_count <= sat_add16(chk_err_count, nfail);
      if (!chk_error) begin
        chk_error    <= 1'b1;
        chk_err_pc   <= first_pc;
        chk_err_insn <= first_insn;
        chk_err_chan <= first_chan;
      end
    end
  end

`ifdef MEMCHECK_FORMAL_EN
  logic        pend_p1;
  logic [31:0] addr_p1, wdata_p1;
  logic [3:0]  wstrb_p1;

  // Mismatch assertion and bus-stability assumption against last cycle.
  always_ff @(posedge clk) begin
    pend_p1  <= resetn && mem_valid && !mem_ready;
    addr_p1  <= mem_addr;
    wdata_p1 <= mem_wdata;
    wstrb_p1 <= mem_wstrb;
    if (resetn) begin
      assert (fail == '0);
      if (pend_p1 && mem_valid)
        assume (mem_addr == addr_p1 && mem_wdata == wdata_p1 && mem_wstrb == wstrb_p1);
    end
  end
`endif

endmodule

// File: tb/tb_rvfi_imem_check.sv
// Self-checking bench for rvfi_imem_check (ADDR_BITS=11, NRET=2,
// COMPRESSED=0, MAX_WAIT=4). Bus transfers push expected read data and
// latency to a scoreboard queue that is popped when mem_ready appears.
module tb_rvfi_imem_check;
  localparam int AB = 11;
  localparam int NR = 2;
  localparam int MW = 4;
  localparam int WWID = 3;

  logic            clk = 1'b0;
  logic            resetn;
  logic            mem_valid, mem_instr, mem_ready;
  logic [31:0]     mem_addr, mem_wdata, mem_rdata;
  logic [3:0]      mem_wstrb;
  logic [WWID-1:0] wait_cycles;
  logic [NR-1:0]   rvfi_valid;
  logic [32*NR-1:0] rvfi_insn, rvfi_pc_rdata;
  logic            chk_error, proto_err;
  logic [15:0]     chk_err_count;
  logic [31:0]     chk_err_pc, chk_err_insn;
  logic [7:0]      chk_err_chan;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model_mem [1024];
  int          n_tests = 0;
  int          n_fail = 0;
  logic        snap_en;
  logic [31:0] snap_pc, snap_insn;

  always #5 clk = ~clk;

  rvfi_imem_check #(
    .ADDR_BITS(AB), .NRET(NR), .COMPRESSED(0), .MAX_WAIT(MW), .WW(WWID)
  ) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .wait_cycles(wait_cycles),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .rvfi_valid(rvfi_valid), .rvfi_insn(rvfi_insn), .rvfi_pc_rdata(rvfi_pc_rdata),
    .chk_error(chk_error), .chk_err_count(chk_err_count), .chk_err_pc(chk_err_pc),
    .chk_err_insn(chk_err_insn), .chk_err_chan(chk_err_chan), .proto_err(proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mem_valid  = 1'b0;
    mem_wstrb  = 4'h0;
    rvfi_valid = '0;
    resetn     = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  // One bus transfer; optionally retires snap_pc/snap_insn in the ready cycle.
  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int wt);
    exp_t e;
    int   h, h1, cyc;
    h  = int'(addr[10:2]) * 2;
    h1 = (h + 1) % 1024;
    e.rdata = {model_mem[h1], model_mem[h]};
    e.lat   = 1 + ((wt > MW) ? MW : wt);
    sb.push_back(e);
    if (wstrb[0]) model_mem[h][7:0]   = wdata[7:0];
    if (wstrb[1]) model_mem[h][15:8]  = wdata[15:8];
    if (wstrb[2]) model_mem[h1][7:0]  = wdata[23:16];
    if (wstrb[3]) model_mem[h1][15:8] = wdata[31:24];
    mem_addr    = addr;
    mem_wdata   = wdata;
    mem_wstrb   = wstrb;
    wait_cycles = WWID'(wt);
    mem_valid   = 1'b1;
    #1;
    n_tests++;
    if (mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_in_request_cycle: mem_ready=%b required 0", mem_ready);
    end
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (mem_ready !== 1'b1 && cyc < 20);
    e = sb.pop_front();
    n_tests++;
    if (cyc != e.lat) begin
      n_fail++;
      $display("FAIL ready_latency addr=%h: got %0d cycles required %0d", addr, cyc, e.lat);
    end
    n_tests++;
    if (mem_rdata !== e.rdata) begin
      n_fail++;
      $display("FAIL rdata addr=%h: got %h required %h", addr, mem_rdata, e.rdata);
    end
    if (snap_en) begin
      rvfi_valid    = 2'b01;
      rvfi_pc_rdata = {32'h0, snap_pc};
      rvfi_insn     = {32'h0, snap_insn};
    end
    tick();
    mem_valid  = 1'b0;
    mem_wstrb  = 4'h0;
    rvfi_valid = '0;
  endtask

  task automatic retire(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] insn0,
                        input logic [31:0] pc1, input logic [31:0] insn1);
    rvfi_valid    = v;
    rvfi_pc_rdata = {pc1, pc0};
    rvfi_insn     = {insn1, insn0};
    tick();
    rvfi_valid = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({mem_ready, proto_err, chk_error, mem_rdata, chk_err_count, chk_err_pc,
         chk_err_insn, chk_err_chan} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b proto=%b err=%b rdata=%h cnt=%h pc=%h insn=%h chan=%h required all 0",
               mem_ready, proto_err, chk_error, mem_rdata, chk_err_count, chk_err_pc,
               chk_err_insn, chk_err_chan);
    end
    resetn = 1'b1;
  endtask

  task automatic test_read();
    bus_xfer(32'h20, 32'h00100093, 4'hF, 0);
    bus_xfer(32'h20, 32'h0, 4'h0, 0);
    n_tests++;
    if (mem_rdata !== 32'h00100093) begin
      n_fail++;
      $display("FAIL read_held: got %h required 00100093", mem_rdata);
    end
    bus_xfer(32'h22, 32'h0, 4'h0, 0);
  endtask

  task automatic test_wait_states();
    bus_xfer(32'h20, 32'h0, 4'h0, 3);
    bus_xfer(32'h20, 32'h0, 4'h0, 7);
    bus_xfer(32'h20, 32'h0, 4'h0, 4);
    bus_xfer(32'h20, 32'h0, 4'h0, 1);
  endtask

  task automatic test_back_to_back();
    bus_xfer(32'h24, 32'h00200113, 4'hF, 0);
    bus_xfer(32'h24, 32'h0, 4'h0, 0);
    bus_xfer(32'h20, 32'h0, 4'h0, 2);
  endtask

  task automatic test_byte_write();
    bus_xfer(32'h20, 32'hAABBCCDD, 4'b0101, 0);
    bus_xfer(32'h20, 32'h0, 4'h0, 0);
    n_tests++;
    if (mem_rdata !== 32'h00BB00DD) begin
      n_fail++;
      $display("FAIL byte_write_read: got %h required 00BB00DD", mem_rdata);
    end
    bus_xfer(32'h20, 32'h00100093, 4'hF, 0);
  endtask

  task automatic test_retire();
    retire(2'b01, 32'h20, 32'h00100093, 32'h0, 32'h0);
    n_tests++;
    if ({chk_error, chk_err_count} !== 17'h0) begin
      n_fail++;
      $display("FAIL retire_match: err=%b cnt=%h required 0/0000", chk_error, chk_err_count);
    end
    bus_xfer(32'h40, 32'h00A00513, 4'hF, 0);
    snap_en   = 1'b1;
    snap_pc   = 32'h40;
    snap_insn = 32'h00A00513;
    bus_xfer(32'h40, 32'h12345678, 4'hF, 0);
    snap_en = 1'b0;
    n_tests++;
    if ({chk_error, chk_err_count} !== 17'h0) begin
      n_fail++;
      $display("FAIL snapshot_pre_write: err=%b cnt=%h required 0/0000", chk_error, chk_err_count);
    end
    retire(2'b01, 32'h20, 32'h00100013, 32'h0, 32'h0);
    n_tests++;
    if ({chk_error, chk_err_count, chk_err_pc, chk_err_insn, chk_err_chan} !==
        {1'b1, 16'd1, 32'h20, 32'h00100013, 8'd0}) begin
      n_fail++;
      $display("FAIL first_mismatch: err=%b cnt=%h pc=%h insn=%h chan=%h required 1/0001/00000020/00100013/00",
               chk_error, chk_err_count, chk_err_pc, chk_err_insn, chk_err_chan);
    end
    retire(2'b10, 32'h0, 32'h0, 32'h40, 32'h00A00513);
    n_tests++;
    if ({chk_err_count, chk_err_pc, chk_err_insn, chk_err_chan} !==
        {16'd2, 32'h20, 32'h00100013, 8'd0}) begin
      n_fail++;
      $display("FAIL later_mismatch_keeps_capture: cnt=%h pc=%h insn=%h chan=%h required 0002/00000020/00100013/00",
               chk_err_count, chk_err_pc, chk_err_insn, chk_err_chan);
    end
  endtask

  task automatic test_dual_channel();
    do_reset();
    retire(2'b11, 32'h24, 32'h00200193, 32'h20, 32'h00000013);
    n_tests++;
    if ({chk_err_count, chk_err_pc, chk_err_insn, chk_err_chan} !==
        {16'd2, 32'h24, 32'h00200193, 8'd0}) begin
      n_fail++;
      $display("FAIL dual_mismatch: cnt=%h pc=%h insn=%h chan=%h required 0002/00000024/00200193/00",
               chk_err_count, chk_err_pc, chk_err_insn, chk_err_chan);
    end
    do_reset();
    retire(2'b11, 32'h20, 32'h00100093, 32'h24, 32'hFFFFFFFF);
    n_tests++;
    if ({chk_err_count, chk_err_pc, chk_err_insn, chk_err_chan} !==
        {16'd1, 32'h24, 32'hFFFFFFFF, 8'd1}) begin
      n_fail++;
      $display("FAIL chan1_only: cnt=%h pc=%h insn=%h chan=%h required 0001/00000024/ffffffff/01",
               chk_err_count, chk_err_pc, chk_err_insn, chk_err_chan);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus_xfer(32'h7FC, 32'h05134501, 4'hF, 0);
    bus_xfer(32'h000, 32'h0000ABCD, 4'hF, 0);
    retire(2'b01, 32'h7FE, 32'hABCD0513, 32'h0, 32'h0);
    n_tests++;
    if (chk_err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL wrap_match: cnt=%h required 0000", chk_err_count);
    end
    retire(2'b01, 32'h7FE, 32'hABCE0513, 32'h0, 32'h0);
    n_tests++;
    if (chk_err_count !== 16'd1) begin
      n_fail++;
      $display("FAIL wrap_high_half: cnt=%h required 0001", chk_err_count);
    end
    retire(2'b01, 32'h7FC, 32'h00004501, 32'h0, 32'h0);
    n_tests++;
    if (chk_err_count !== 16'd2) begin
      n_fail++;
      $display("FAIL compressed_illegal: cnt=%h required 0002", chk_err_count);
    end
  endtask

  task automatic test_protocol();
    do_reset();
    mem_addr = 32'h20; mem_wdata = 32'hDEADBEEF; mem_wstrb = 4'hF;
    wait_cycles = 3'd3; mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    tick();
    n_tests++;
    if (proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_drop_wait: proto_err=%b required 1", proto_err);
    end
    bus_xfer(32'h20, 32'h0, 4'h0, 0);
    do_reset();
    n_tests++;
    if (proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL proto_cleared_by_reset: proto_err=%b required 0", proto_err);
    end
    mem_addr = 32'h20; mem_wdata = 32'hDEADBEEF; mem_wstrb = 4'hF;
    wait_cycles = 3'd0; mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    #1;
    n_tests++;
    if (mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL proto_drop_resp_ready: mem_ready=%b required 0", mem_ready);
    end
    tick();
    mem_wstrb = 4'h0;
    n_tests++;
    if (proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_drop_resp: proto_err=%b required 1", proto_err);
    end
    bus_xfer(32'h20, 32'h0, 4'h0, 0);
  endtask

  task automatic test_reset_mid();
    mem_addr = 32'h20; mem_wstrb = 4'h0; wait_cycles = 3'd3; mem_valid = 1'b1;
    tick();
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    n_tests++;
    if (mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_after_reset: mem_ready=%b required 0", mem_ready);
    end
    mem_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    rvfi_valid    = 2'b11;
    rvfi_pc_rdata = {32'h20, 32'h20};
    rvfi_insn     = {32'h0, 32'h0};
    repeat (32767) tick();
    n_tests++;
    if (chk_err_count !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL count_near_sat: cnt=%h required fffe", chk_err_count);
    end
    tick();
    n_tests++;
    if (chk_err_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL count_saturates: cnt=%h required ffff", chk_err_count);
    end
    tick();
    n_tests++;
    if (chk_err_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL count_stays_sat: cnt=%h required ffff", chk_err_count);
    end
    rvfi_valid = '0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model_mem[i] = 16'h0000;
    resetn = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0;
    mem_wdata = '0; mem_wstrb = '0; wait_cycles = '0; rvfi_valid = '0;
    rvfi_insn = '0; rvfi_pc_rdata = '0; snap_en = 1'b0; snap_pc = '0; snap_insn = '0;
    test_reset();
    test_read();
    test_wait_states();
    test_back_to_back();
    test_byte_write();
    test_retire();
    test_dual_channel();
    test_wrap();
    test_protocol();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
